// File: rtl/sw_debounce_sync.sv
// Per-channel input conditioner: SYNC_STAGES-deep synchronizer feeding a
// counter-based debounce FSM with registered level, rise/fall strobes and any_change.
module sw_debounce_sync #(
  parameter int              NCH         = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              DB_CYCLES   = 48000,
  parameter int              CNT_W       = 16,
  parameter logic [NCH-1:0]  RST_VAL     = '0
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [NCH-1:0] raw_in,
  output logic [NCH-1:0] db_out,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_change
);

  typedef enum logic {STABLE = 1'b0, PEND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NCH-1:0] rise_d;
  logic [NCH-1:0] fall_d;
  logic           any_change_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      state_t                 state_reg, state_next;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic                   db_reg, db_next;
      logic                   rise_reg, rise_next;
      logic                   fall_reg, fall_next;
      logic                   accept;

      // Plain flop chain; nothing may sit between the stages.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          sync_reg <= {SYNC_STAGES{RST_VAL[gi]}};
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
          db_reg    <= RST_VAL[gi];
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          db_reg    <= db_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          STABLE: begin
            if (s != db_reg) begin
              state_next = PEND;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next   = '0;
            end
          end
          PEND: begin
            if (s == db_reg || cnt_reg == CNT_LAST) begin
              state_next = STABLE;
              cnt_next   = '0;
            end else begin
              cnt_next   = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = STABLE;
            cnt_next   = '0;
          end
        endcase
      end

      // Acceptance uses the s sampled this cycle, even if it flips right after.
      always_comb begin
        accept    = (state_reg == PEND) && (s != db_reg) && (cnt_reg == CNT_LAST);
        db_next   = accept ? s : db_reg;
        rise_next = accept & s;
        fall_next = accept & ~s;
      end

      assign db_out[gi] = db_reg;
      assign rise[gi]   = rise_reg;
      assign fall[gi]   = fall_reg;
      assign rise_d[gi] = rise_next;
      assign fall_d[gi] = fall_next;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      any_change_reg <= 1'b0;
    end else begin
      any_change_reg <= |(rise_d | fall_d);
    end
  end

  assign any_change = any_change_reg;

endmodule

// File: doc/sw_debounce_sync.md
Name: sw_debounce_sync

Overview:
- Conditions raw asynchronous board inputs (slide switches SW[8:1], push keys) before they reach the leon3mp core pins (resetn, dsuen, dsubre, boot_select, ...).
- Per channel: multi-stage synchronizer, then a counter-based debounce FSM. Outputs a clean level plus single-cycle rise/fall strobes.
- Sits directly upstream of the processor top, in the CLOCK_48 domain.

Parameters:
- NCH, 8, number of independent input channels.
- SYNC_STAGES, 2, flip-flops in each synchronizer chain (legal range 2..4).
- DB_CYCLES, 48000, cycles an input must stay stable before it is accepted (1 ms at 48 MHz). Minimum 2.
- CNT_W, 16, stability-counter width. Must satisfy 2^CNT_W > DB_CYCLES.
- RST_VAL, {NCH{1'b0}}, per-channel reset level applied to the sync chain and db_out.

Ports:
- clk  in  1  system clock (CLOCK_48 domain).
- resetn  in  1  asynchronous active-low reset.
- raw_in  in  NCH  unsynchronized board inputs.
- db_out  out  NCH  debounced level.
- rise  out  NCH  one-cycle strobe on an accepted 0->1 change.
- fall  out  NCH  one-cycle strobe on an accepted 1->0 change.
- any_change  out  1  OR of all rise and fall bits, registered with them.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All sync flops and db_out are set to RST_VAL.
  - All counters are cleared to 0.
  - rise, fall and any_change are 0.
  - Values hold until the first clk edge after resetn deasserts.
- Synchronizer: s[i] is raw_in[i] delayed by SYNC_STAGES flops. No logic is placed between the flops.
- Per-channel FSM states:
  - STABLE: s==db_out.
  - PEND: s!=db_out, counting.
- STABLE:
  - cnt held at 0.
  - When s!=db_out, go to PEND and set cnt<=1.
- PEND, s reverts (s==db_out): go to STABLE and set cnt<=0. No output change (glitch rejected).
- PEND, s!=db_out and cnt<DB_CYCLES-1: cnt<=cnt+1.
- PEND, s!=db_out and cnt==DB_CYCLES-1:
  - db_out<=s, cnt<=0, go to STABLE.
  - In the same cycle, register rise<=s or fall<=~s.
- Strobe timing:
  - A strobe is high for exactly one cycle, coincident with the first cycle db_out shows the new value.
  - Strobes are low in every other cycle.
- Latency: from s first differing from db_out, db_out changes after exactly DB_CYCLES cycles. From raw_in, latency is SYNC_STAGES+DB_CYCLES cycles, plus up to one cycle of sampling uncertainty.
- Glitch rejection:
  - A pulse on s shorter than DB_CYCLES cycles never changes db_out.
  - A pulse of exactly DB_CYCLES cycles is accepted.
- Counter range: cnt never exceeds DB_CYCLES-1 and never wraps.
- Channels are fully independent:
  - Simultaneous acceptances on several channels assert multiple rise/fall bits in the same cycle.
  - any_change is a single pulse for that cycle.
- Reset mid-PEND: the counter is lost and db_out returns to RST_VAL. After release, a still-differing input re-qualifies from cnt=0.
- Edge at exact acceptance: if s toggles back in the acceptance cycle, acceptance still occurs, because the decision uses the s value sampled that cycle. A new PEND then starts from STABLE on the next cycle.
- No combinational path from raw_in to any output. All outputs are registered.

Test Plan:
- Reset:
  - Stimulus: NCH=8, DB_CYCLES=4, RST_VAL=8'h00, raw_in=8'hFF during reset.
  - Required: db_out=8'h00 and rise=fall=0 throughout reset.
  - Required after release: db_out=8'hFF exactly SYNC_STAGES+4 cycles later, with rise=8'hFF for one cycle and any_change=1 for one cycle.
- Glitch rejection:
  - Stimulus: raw_in[0] high for 3 cycles, then low.
  - Required: db_out[0] stays 0 and rise[0] never asserts.
- Boundary acceptance:
  - Stimulus: raw_in[0] high for exactly 4 cycles.
  - Required: db_out[0]=1 after SYNC_STAGES+4 cycles.
  - Required: when the input returns low, fall[0] pulses 4 cycles after s[0] drops.
- Bounce train:
  - Stimulus: raw_in[2] toggles 1,0,1,1,0,1,1,1,1 with one value per cycle.
  - Required: a single rise[2] pulse, emitted only after the final 4-cycle stable run; no intermediate strobes.
- Simultaneous events:
  - Stimulus: raw_in[5] 0->1 and raw_in[6] 1->0 (from a settled 1) on the same cycle.
  - Required: rise[5]=1, fall[6]=1 and any_change=1, all in the same single cycle.
- Reset mid-PEND:
  - Stimulus: assert resetn low at cnt=2 with raw_in[1]=1, hold it low for 3 cycles, then release.
  - Required: db_out[1]=0 during reset; acceptance occurs SYNC_STAGES+4 cycles after release, not earlier.
